display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 4-digit common-anode 7-segment display. Holds a 16-bit BCD value (4 nibbles) and cycles through the digits at a programmable refresh rate. Each digit period starts with an anti-ghosting dead time. Drives the combinational segment decoder with one BCD nibble plus an active-low anode select. New values are taken through a double-buffered load/ack handshake and applied only at frame boundaries, so the display never shows a torn frame.

---
 rtl/display_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Purpose : time-multiplexed scan of a 4-digit common-anode 7-segment display with dead time and lz blanking.
// Latency : all outputs registered; a load is applied at the next frame wrap (or the next edge while off).
// Backpr. : none; load is a strobe, a later load before apply overwrites the shadow value.
module display_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic        load,
  input  logic [15:0] value,
  output logic        load_ack,
  output logic [3:0]  digit_data,
  output logic [3:0]  dig_sel
);

  localparam int            CW         = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam bit            NO_BLANK   = (BLANK_CYC == 0);
  // Last dead-time count; unused when there is no dead time.
  localparam logic [CW-1:0] BLANK_LAST = NO_BLANK ? '0 : CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic          pending;

  logic          period_end;
  logic          frame_end;
  logic          apply;
  logic [15:0]   active_nxt;

  // Anode select and nibble for one lit digit; digits above the most
  // significant non-zero nibble go dark when lz blanking is on.
  function automatic logic [7:0] digit_view(input logic [1:0] i,
                                            input logic [15:0] v,
                                            input logic lz);
    logic [3:0] nib;
    logic       dark;
    nib = v[{i, 2'b00} +: 4];
    case (i)
      2'd1:    dark = lz && (v[15:4] == 12'h000);
      2'd2:    dark = lz && (v[15:8] == 8'h00);
      2'd3:    dark = lz && (v[15:12] == 4'h0);
      default: dark = 1'b0;
    endcase
    return {~(4'b0001 << i), (dark ? 4'hF : nib)};
  endfunction

  // Frame-boundary detection and the value that will be on display after this edge.
  always_comb begin
    period_end = (state != OFF) && (cnt == CNT_LAST);
    frame_end  = enable && period_end && (idx == 2'd3);
    apply      = pending && ((state == OFF) || frame_end);
    active_nxt = apply ? shadow : active;
  end

  // Scan FSM, load handshake and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      cnt        <= '0;
      idx        <= 2'd0;
      active     <= 16'h0000;
      shadow     <= 16'h0000;
      pending    <= 1'b0;
      dig_sel    <= 4'hF;
      digit_data <= 4'hF;
      load_ack   <= 1'b0;
    end else begin
      load_ack <= apply;
      active   <= active_nxt;
      // A load on the apply edge is kept for the next boundary.
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      if (!enable) begin
        state      <= OFF;
        cnt        <= '0;
        idx        <= 2'd0;
        dig_sel    <= 4'hF;
        digit_data <= 4'hF;
      end else begin
        case (state)
          OFF: begin
            cnt <= '0;
            idx <= 2'd0;
            if (NO_BLANK) begin
              state                 <= SHOW;
              {dig_sel, digit_data} <= digit_view(2'd0, active_nxt, blank_lz);
            end else begin
              state      <= BLANK;
              dig_sel    <= 4'hF;
              digit_data <= 4'hF;
            end
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) begin
              state                 <= SHOW;
              {dig_sel, digit_data} <= digit_view(idx, active_nxt, blank_lz);
            end else begin
              dig_sel    <= 4'hF;
              digit_data <= 4'hF;
            end
          end
          SHOW: begin
            if (period_end) begin
              cnt <= '0;
              idx <= idx + 2'd1;
              if (NO_BLANK) begin
                state                 <= SHOW;
                {dig_sel, digit_data} <= digit_view(idx + 2'd1, active_nxt, blank_lz);
              end else begin
                state      <= BLANK;
                dig_sel    <= 4'hF;
                digit_data <= 4'hF;
              end
            end else begin
              cnt                   <= cnt + 1'b1;
              {dig_sel, digit_data} <= digit_view(idx, active_nxt, blank_lz);
            end
          end
          default: begin
            state      <= OFF;
            cnt        <= '0;
            idx        <= 2'd0;
            dig_sel    <= 4'hF;
            digit_data <= 4'hF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Purpose : exercises two scan controllers (8/2 and 2/0 timing) against a time-position reference model.
// Latency : expectations are queued per driven cycle and checked one edge later.
// Backpr. : none; the monitor pops one expectation per clock while any are queued.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;

  logic        ack8, ack2;
  logic [3:0]  dd8, ds8, dd2, ds2;

  display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .blank_lz(blank_lz), .load(load),
    .value(value), .load_ack(ack8), .digit_data(dd8), .dig_sel(ds8));

  display_scan_ctrl #(.CLK_DIV(2), .BLANK_CYC(0)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .blank_lz(blank_lz), .load(load),
    .value(value), .load_ack(ack2), .digit_data(dd2), .dig_sel(ds2));

  always #5 clk = ~clk;

  typedef struct packed {
    bit          on;
    int          t;        // cycles since scan start, modulo one frame
    logic [15:0] active;
    logic [15:0] shadow;
    bit          pending;
    logic [3:0]  sel;
    logic [3:0]  data;
    logic        ack;
  } model_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] data;
    logic       ack;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  exp_t   q8[$];
  exp_t   q2[$];
  model_t m8 = '0;
  model_t m2 = '0;
  logic   cur_en = 1'b0;
  logic   cur_lz = 1'b0;

  // Reference: position within the frame decides digit and dead time directly.
  function automatic model_t model_next(model_t m, int div, int blk, logic r, logic en,
                                        logic lz, logic ld, logic [15:0] v);
    model_t      n;
    int          frame;
    int          dig;
    int          ph;
    bit          apply;
    logic [15:0] upper;
    frame = 4 * div;
    n = m;
    if (r) begin
      n      = '0;
      n.sel  = 4'hF;
      n.data = 4'hF;
      return n;
    end
    apply = m.pending && (!m.on || (en && (m.t % frame == frame - 1)));
    n.ack = apply;
    if (apply) n.active = m.shadow;
    if (ld) begin
      n.shadow  = v;
      n.pending = 1'b1;
    end else if (apply) begin
      n.pending = 1'b0;
    end
    if (!en) begin
      n.on = 1'b0;
      n.t  = 0;
    end else if (!m.on) begin
      n.on = 1'b1;
      n.t  = 0;
    end else begin
      n.t = (m.t + 1) % frame;
    end
    n.sel  = 4'hF;
    n.data = 4'hF;
    if (n.on) begin
      dig = (n.t / div) % 4;
      ph  = n.t % div;
      if (ph >= blk) begin
        upper  = n.active >> (4 * dig);
        n.sel  = ~(4'b0001 << dig);
        n.data = (lz && dig > 0 && upper == 16'h0000) ? 4'hF : upper[3:0];
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, queue both models' expected outputs, wait for the next negedge.
  task automatic drive(input logic r, input logic en, input logic lz, input logic ld,
                       input logic [15:0] v);
    rst      = r;
    enable   = en;
    blank_lz = lz;
    load     = ld;
    value    = v;
    m8 = model_next(m8, 8, 2, r, en, lz, ld, v);
    m2 = model_next(m2, 2, 0, r, en, lz, ld, v);
    q8.push_back({m8.sel, m8.data, m8.ack});
    q2.push_back({m2.sel, m2.data, m2.ack});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, cur_en, cur_lz, 1'b0, 16'h0000);
  endtask

  task automatic do_load(input logic [15:0] v);
    drive(1'b0, cur_en, cur_lz, 1'b1, v);
  endtask

  // Monitor: compare whatever the DUTs present after each edge with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("d8 dig_sel", {12'h000, ds8}, {12'h000, e.sel});
        check("d8 digit_data", {12'h000, dd8}, {12'h000, e.data});
        check("d8 load_ack", {15'h0000, ack8}, {15'h0000, e.ack});
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("d2 dig_sel", {12'h000, ds2}, {12'h000, e.sel});
        check("d2 digit_data", {12'h000, dd2}, {12'h000, e.data});
        check("d2 load_ack", {15'h0000, ack2}, {15'h0000, e.ack});
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic        r;
    logic        ld;
    @(negedge clk);

    // Reset values.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("reset dig_sel", {12'h000, ds8}, 16'h000F);
    check("reset digit_data", {12'h000, dd8}, 16'h000F);
    check("reset load_ack", {15'h0000, ack8}, 16'h0000);
    check("reset d2 dig_sel", {12'h000, ds2}, 16'h000F);

    // Load while off: ack one cycle after the strobe, then drops.
    do_load(16'h1234);
    idle(1);
    check("off-apply ack d8", {15'h0000, ack8}, 16'h0001);
    check("off-apply ack d2", {15'h0000, ack2}, 16'h0001);
    idle(1);
    check("ack single cycle", {15'h0000, ack8}, 16'h0000);

    // Scan start: two dead cycles then digit 0, each digit 8 cycles later.
    cur_en = 1'b1;
    idle(1);
    check("first blank dig_sel", {12'h000, ds8}, 16'h000F);
    idle(2);
    check("digit0 sel", {12'h000, ds8}, 16'h000E);
    check("digit0 data", {12'h000, dd8}, 16'h0004);
    idle(8);
    check("digit1 sel", {12'h000, ds8}, 16'h000D);
    check("digit1 data", {12'h000, dd8}, 16'h0003);
    idle(8);
    check("digit2 sel", {12'h000, ds8}, 16'h000B);
    check("digit2 data", {12'h000, dd8}, 16'h0002);
    idle(8);
    check("digit3 sel", {12'h000, ds8}, 16'h0007);
    check("digit3 data", {12'h000, dd8}, 16'h0001);

    // Mid-frame load, then two loads within one frame.
    idle(16);
    do_load(16'h5678);
    idle(40);
    idle(3);
    do_load(16'h1111);
    idle(5);
    do_load(16'h2222);
    idle(70);

    // Leading-zero blanking.
    cur_lz = 1'b1;
    do_load(16'h0040);
    idle(70);
    do_load(16'h0000);
    idle(70);
    cur_lz = 1'b0;
    idle(40);

    // Drop enable while a digit is lit, then restart.
    for (int i = 0; i < 8 && m8.sel == 4'hF; i++) idle(1);
    cur_en = 1'b0;
    idle(1);
    check("disable dig_sel", {12'h000, ds8}, 16'h000F);
    check("disable digit_data", {12'h000, dd8}, 16'h000F);
    idle(3);
    cur_en = 1'b1;
    idle(1);
    check("restart blank", {12'h000, ds8}, 16'h000F);
    idle(2);
    check("restart idx0", {12'h000, ds8}, 16'h000E);

    // Reset with a load pending: no ack afterwards, display shows zero.
    idle(5);
    do_load(16'h9999);
    idle(2);
    repeat (2) drive(1'b1, cur_en, cur_lz, 1'b0, 16'h0000);
    cur_en = 1'b0;
    idle(3);
    check("no ack after reset", {15'h0000, ack8}, 16'h0000);
    cur_en = 1'b1;
    idle(3);
    check("post-reset digit0 sel", {12'h000, ds8}, 16'h000E);
    check("post-reset digit0 data", {12'h000, dd8}, 16'h0000);
    idle(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      if (cur_en ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) == 0)) cur_en = ~cur_en;
      if ($urandom_range(0, 199) == 0) cur_lz = ~cur_lz;
      ld = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < 4; k++) v[4*k +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      drive(r, cur_en, cur_lz, ld, v);
    end

    idle(2);
    repeat (2) @(negedge clk);
    check("q8 drained", 16'(q8.size()), 16'h0000);
    check("q2 drained", 16'(q2.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
